// File: rtl/unified_mem_arbiter.sv
// Arbitrates the RV32I fetch and load/store ports onto one single-ported memory.
// Optional macro ARB_ROUND_ROBIN_EN: alternate ties between ports instead of data-first priority.
module unified_mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_done,
    output logic [XLEN-1:0] i_rdata,
    output logic            i_fault,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [1:0]      d_width,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_done,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_fault,
    output logic            m_en,
    output logic            m_we,
    output logic [1:0]      m_width,
    output logic [XLEN-1:0] m_addr,
    output logic [XLEN-1:0] m_wdata,
    input  logic [XLEN-1:0] m_rdata
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("unified_mem_arbiter: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic            win_d;
    logic            any_req;
    logic            prefer_d;
    logic            gnt_d;
    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] sel_wdata;
    logic [1:0]      sel_width;
    logic            sel_we;
    logic            sel_fault;
    logic            enter_resp;
    logic            resp_win_d;
    logic            resp_fault;
    logic [XLEN-1:0] resp_rdata;

    // Width 3 is never legal; half and word must be naturally aligned.
    function automatic logic misaligned(input logic [1:0] width, input logic [1:0] lsb);
        case (width)
            2'd0:    return 1'b0;
            2'd1:    return lsb[0];
            2'd2:    return lsb != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_d <= 1'b0;
        end else if (state == IDLE && any_req) begin
            last_grant_d <= gnt_d;
        end
    end

    assign prefer_d = ~last_grant_d;
`else
    assign prefer_d = 1'b1;
`endif

    assign any_req   = i_req | d_req;
    assign gnt_d     = d_req & (~i_req | prefer_d);
    assign sel_addr  = gnt_d ? d_addr : i_addr;
    assign sel_width = gnt_d ? d_width : 2'd2;
    assign sel_we    = gnt_d & d_we;
    assign sel_wdata = gnt_d ? d_wdata : '0;
    assign sel_fault = misaligned(sel_width, sel_addr[1:0]);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = sel_fault ? RESP : ISSUE;
            ISSUE:   state_nxt = (LATENCY > 1) ? WAIT : RESP;
            WAIT:    if (cnt == 4'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Only a faulted grant enters RESP straight from IDLE; memory accesses arrive via ISSUE/WAIT.
    assign enter_resp = (state_nxt == RESP);
    assign resp_win_d = (state == IDLE) ? gnt_d : win_d;
    assign resp_fault = (state == IDLE) & sel_fault;
    assign resp_rdata = (state != IDLE && !m_we) ? m_rdata : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            win_d   <= 1'b0;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_width <= 2'd0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_done  <= 1'b0;
            i_fault <= 1'b0;
            i_rdata <= '0;
            d_done  <= 1'b0;
            d_fault <= 1'b0;
            d_rdata <= '0;
        end else begin
            state <= state_nxt;
            m_en  <= (state_nxt == ISSUE);
            // The memory-side registers double as the latch for the granted request.
            if (state == IDLE && any_req) begin
                win_d   <= gnt_d;
                m_we    <= sel_we;
                m_width <= sel_width;
                m_addr  <= sel_addr;
                m_wdata <= sel_wdata;
            end
            if (state == ISSUE) begin
                cnt <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            i_done  <= enter_resp & ~resp_win_d;
            i_fault <= enter_resp & ~resp_win_d & resp_fault;
            i_rdata <= (enter_resp && !resp_win_d) ? resp_rdata : '0;
            d_done  <= enter_resp & resp_win_d;
            d_fault <= enter_resp & resp_win_d & resp_fault;
            d_rdata <= (enter_resp && resp_win_d) ? resp_rdata : '0;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter with a byte-addressed fixed-latency memory model.
module tb_unified_mem_arbiter;

    localparam int LAT = 3;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          fault;
        int          cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        i_fault;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_width;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_fault;
    logic        m_en;
    logic        m_we;
    logic [1:0]  m_width;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    int          men_count = 0;
    int          men_last_cyc = -1;
    logic [31:0] men_last_addr;
    logic        men_last_we;
    logic [1:0]  men_last_width;
    logic [31:0] men_last_wdata;

    logic [7:0]  mem [0:4095];
    bit          mem_ready;
    logic [31:0] rd0;
    logic [31:0] rd_pipe [0:LAT-1];

    localparam logic [31:0] FETCH_W = 32'h0050_0093;

    unified_mem_arbiter #(.XLEN(32), .LATENCY(LAT)) dut (
        .clock(clock), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_fault(i_fault),
        .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_fault(d_fault),
        .m_en(m_en), .m_we(m_we), .m_width(m_width), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    // Memory: writes on the m_en edge; reads appear LAT-1 cycles after the m_en cycle so the
    // arbiter captures them exactly LAT edges after presenting the address (LAT >= 2 here).
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int a = 0; a < 4096; a++) mem[a] <= init_byte(a);
            mem[12'h100] <= 8'h93;
            mem[12'h101] <= 8'h00;
            mem[12'h102] <= 8'h50;
            mem[12'h103] <= 8'h00;
            mem_ready <= 1'b1;
        end else if (m_en === 1'b1 && m_we === 1'b1) begin
            case (m_width)
                2'd0: mem[m_addr[11:0]] <= m_wdata[7:0];
                2'd1: begin
                    mem[m_addr[11:0]]         <= m_wdata[7:0];
                    mem[m_addr[11:0] + 12'd1] <= m_wdata[15:8];
                end
                default: begin
                    mem[m_addr[11:0]]         <= m_wdata[7:0];
                    mem[m_addr[11:0] + 12'd1] <= m_wdata[15:8];
                    mem[m_addr[11:0] + 12'd2] <= m_wdata[23:16];
                    mem[m_addr[11:0] + 12'd3] <= m_wdata[31:24];
                end
            endcase
        end
    end

    assign rd0 = (m_en === 1'b1 && m_we === 1'b0) ?
                 {mem[{m_addr[11:2], 2'b11}], mem[{m_addr[11:2], 2'b10}],
                  mem[{m_addr[11:2], 2'b01}], mem[{m_addr[11:2], 2'b00}]} : 32'hDEAD_BEEF;

    always @(posedge clock) begin
        rd_pipe[0] <= rd0;
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    assign m_rdata = rd_pipe[LAT-2];

    always @(negedge clock) begin
        if (m_en === 1'b1) begin
            men_count      <= men_count + 1;
            men_last_cyc   <= cyc;
            men_last_addr  <= m_addr;
            men_last_we    <= m_we;
            men_last_width <= m_width;
            men_last_wdata <= m_wdata;
        end
    end

    task automatic wait_done(output bit to, output bit gi, output bit gd,
                             output logic [31:0] rd, output bit flt, output int at);
        to = 1'b1; gi = 1'b0; gd = 1'b0; rd = '0; flt = 1'b0; at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (i_done === 1'b1 || d_done === 1'b1) begin
                to  = 1'b0;
                gi  = (i_done === 1'b1);
                gd  = (d_done === 1'b1);
                rd  = gd ? d_rdata : i_rdata;
                flt = gd ? d_fault : i_fault;
                at  = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_width = 2'd0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({i_done, i_fault, d_done, d_fault, m_en, m_we, m_width} !== 8'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {i_done, i_fault, d_done, d_fault, m_en, m_we, m_width});
        end
        checks++;
        if ({m_addr, m_wdata} !== 64'd0) begin
            failures++;
            $display("FAIL reset_m_bus got=%h exp=0", {m_addr, m_wdata});
        end
        checks++;
        if ({i_rdata, d_rdata} !== 64'd0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=0", {i_rdata, d_rdata});
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({i_done, d_done, m_en} !== 3'd0) begin
            failures++;
            $display("FAIL idle_quiet got=%b exp=000", {i_done, d_done, m_en});
        end
    endtask

    task automatic test_fetch();
        exp_t e;
        int   n;
        @(posedge clock); #1;
        i_addr = 32'h100; i_req = 1'b1; n = cyc;
        exp_q.push_back('{1'b0, FETCH_W, 1'b0, n + 1 + LAT});
        for (int c = 0; c <= LAT + 1; c++) begin
            @(negedge clock);
            checks++;
            if (m_en !== (c == 1) || i_done !== (c == LAT + 1) || d_done !== 1'b0) begin
                failures++;
                $display("FAIL fetch_timing c=%0d got m_en=%b i_done=%b d_done=%b", c, m_en, i_done, d_done);
            end
            if (c == 1) begin
                checks++;
                if ({m_addr, m_we, m_width} !== {32'h100, 1'b0, 2'd2}) begin
                    failures++;
                    $display("FAIL fetch_mbus got=%h/%b/%0d exp=00000100/0/2", m_addr, m_we, m_width);
                end
            end
            if (i_done === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if ({i_fault, i_rdata} !== {e.fault, e.rdata} || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL fetch_resp got=%b/%h@%0d exp=%b/%h@%0d", i_fault, i_rdata, cyc, e.fault, e.rdata, e.cyc);
                end
            end
        end
        @(posedge clock); #1;
        i_req = 1'b0;
        @(negedge clock);
        checks++;
        if ({i_done, m_en} !== 2'b00) begin
            failures++;
            $display("FAIL fetch_done_width got=%b exp=00", {i_done, m_en});
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          n, at, first_men, m0;
        bit          to, gi, gd, flt;
        logic [31:0] rd;
        logic [31:0] load_w;
        load_w = {8'hAB, init_byte(32'h202), init_byte(32'h201), init_byte(32'h200)};
        @(posedge clock); #1;
        m0 = men_count;
        d_req = 1'b1; d_we = 1'b1; d_width = 2'd0; d_addr = 32'h203; d_wdata = 32'h0000_00AB; n = cyc;
        exp_q.push_back('{1'b1, 32'd0, 1'b0, n + 1 + LAT});
        wait_done(to, gi, gd, rd, flt, at);
        e = exp_q.pop_front();
        checks++;
        if (to || {gi, gd, flt, rd} !== {!e.is_d, e.is_d, e.fault, e.rdata} || at != e.cyc) begin
            failures++;
            $display("FAIL store_resp got=%b%b/%b/%h@%0d exp d/%b/%h@%0d", gi, gd, flt, rd, at, e.fault, e.rdata, e.cyc);
        end
        checks++;
        if (men_count != m0 + 1 || men_last_cyc != n + 1 ||
            {men_last_addr, men_last_we, men_last_width, men_last_wdata} !== {32'h203, 1'b1, 2'd0, 32'hAB}) begin
            failures++;
            $display("FAIL store_mbus got=%0d@%0d %h/%b/%0d/%h exp 1@%0d 00000203/1/0/000000ab",
                     men_count - m0, men_last_cyc, men_last_addr, men_last_we, men_last_width, men_last_wdata, n + 1);
        end
        first_men = men_last_cyc;
        @(posedge clock); #1;
        d_we = 1'b0; d_width = 2'd2; d_addr = 32'h200; d_wdata = 32'hFFFF_FFFF; n = cyc;
        exp_q.push_back('{1'b1, load_w, 1'b0, n + 1 + LAT});
        wait_done(to, gi, gd, rd, flt, at);
        e = exp_q.pop_front();
        checks++;
        if (to || {gi, gd, flt, rd} !== {!e.is_d, e.is_d, e.fault, e.rdata} || at != e.cyc) begin
            failures++;
            $display("FAIL load_resp got=%b%b/%b/%h@%0d exp d/%b/%h@%0d", gi, gd, flt, rd, at, e.fault, e.rdata, e.cyc);
        end
        checks++;
        if (men_last_cyc - first_men != LAT + 2 || men_last_addr !== 32'h200 || men_last_we !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap got=%0d %h/%b exp=%0d 00000200/0", men_last_cyc - first_men, men_last_addr, men_last_we, LAT + 2);
        end
        @(posedge clock); #1;
        d_req = 1'b0;
    endtask

    task automatic test_misaligned();
        bit          cd [4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        bit          cwe [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0]  cw [4]  = '{2'd2, 2'd3, 2'd1, 2'd2};
        logic [31:0] ca [4]  = '{32'h202, 32'h100, 32'h201, 32'h102};
        exp_t        e;
        int          n, at, m0;
        bit          to, gi, gd, flt;
        logic [31:0] rd;
        m0 = men_count;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            if (cd[k]) begin
                d_we = cwe[k]; d_width = cw[k]; d_addr = ca[k]; d_wdata = 32'h1234_5678; d_req = 1'b1;
            end else begin
                i_addr = ca[k]; i_req = 1'b1;
            end
            n = cyc;
            exp_q.push_back('{cd[k], 32'd0, 1'b1, n + 1});
            wait_done(to, gi, gd, rd, flt, at);
            e = exp_q.pop_front();
            checks++;
            if (to || {gi, gd, flt, rd} !== {!e.is_d, e.is_d, e.fault, e.rdata} || at != e.cyc) begin
                failures++;
                $display("FAIL fault_case%0d got=%b%b/%b/%h@%0d exp %b/1/0@%0d", k, gi, gd, flt, rd, at, e.is_d, e.cyc);
            end
            @(posedge clock); #1;
            i_req = 1'b0; d_req = 1'b0;
        end
        checks++;
        if (men_count != m0) begin
            failures++;
            $display("FAIL fault_no_mem got=%0d accesses exp=0", men_count - m0);
        end
    endtask

    task automatic test_contention();
        exp_t        e;
        int          n, at;
        bit          to, gi, gd, flt;
        logic [31:0] rd;
        logic [31:0] load_w;
        bit   [4:0]  ord;
`ifdef ARB_ROUND_ROBIN_EN
        ord = 5'b10101;
`else
        ord = 5'b01111;
`endif
        load_w = {8'hAB, init_byte(32'h202), init_byte(32'h201), init_byte(32'h200)};
        @(posedge clock); #1;
        i_addr = 32'h100; d_we = 1'b0; d_width = 2'd2; d_addr = 32'h200;
        i_req = 1'b1; d_req = 1'b1; n = cyc;
        for (int k = 0; k < 5; k++)
            exp_q.push_back('{ord[k], ord[k] ? load_w : FETCH_W, 1'b0, n + k * (LAT + 2) + LAT + 1});
        for (int k = 0; k < 5; k++) begin
            wait_done(to, gi, gd, rd, flt, at);
            e = exp_q.pop_front();
            checks++;
            if (to || {gi, gd, flt, rd} !== {!e.is_d, e.is_d, e.fault, e.rdata} || at != e.cyc) begin
                failures++;
                $display("FAIL contend%0d got i=%b d=%b/%b/%h@%0d exp d=%b/%h@%0d", k, gi, gd, flt, rd, at, e.is_d, e.rdata, e.cyc);
            end
            if (k == 3) begin
                @(posedge clock); #1;
                if (ord[3]) d_req = 1'b0;
                else        i_req = 1'b0;
            end
        end
        @(posedge clock); #1;
        i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t        e;
        int          n, at;
        bit          to, gi, gd, flt;
        logic [31:0] rd;
        @(posedge clock); #1;
        d_we = 1'b0; d_width = 2'd2; d_addr = 32'h200; d_req = 1'b1; n = cyc;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (m_en !== 1'b1 || m_addr !== 32'h200) begin
            failures++;
            $display("FAIL rst_mid_issue got=%b/%h exp=1/00000200", m_en, m_addr);
        end
        @(posedge clock); #1;
        reset_n = 1'b0; d_req = 1'b0;
        #1;
        checks++;
        if ({i_done, i_fault, d_done, d_fault, m_en, m_we, m_width, m_addr, m_wdata, i_rdata, d_rdata} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs got en=%b addr=%h wd=%h d_rdata=%h exp all 0", m_en, m_addr, m_wdata, d_rdata);
        end
        for (int c = 0; c < LAT + 3; c++) begin
            @(negedge clock);
            checks++;
            if ({i_done, d_done} !== 2'b00) begin
                failures++;
                $display("FAIL rst_mid_no_done c=%0d got=%b exp=00", c, {i_done, d_done});
            end
        end
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        i_addr = 32'h100; i_req = 1'b1; n = cyc;
        exp_q.push_back('{1'b0, FETCH_W, 1'b0, n + 1 + LAT});
        wait_done(to, gi, gd, rd, flt, at);
        e = exp_q.pop_front();
        checks++;
        if (to || {gi, gd, flt, rd} !== {!e.is_d, e.is_d, e.fault, e.rdata} || at != e.cyc) begin
            failures++;
            $display("FAIL rst_mid_refetch got=%b%b/%b/%h@%0d exp i/%b/%h@%0d", gi, gd, flt, rd, at, e.fault, e.rdata, e.cyc);
        end
        checks++;
        if (men_last_cyc != n + 1 || men_last_addr !== 32'h100) begin
            failures++;
            $display("FAIL rst_mid_refetch_men got=%0d/%h exp=%0d/00000100", men_last_cyc, men_last_addr, n + 1);
        end
        @(posedge clock); #1;
        i_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_back_to_back();
        test_misaligned();
        test_contention();
        test_reset_mid();
        repeat (2) @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
